ring_phase_monitor: RTL

RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

---
 rtl/ring_phase_monitor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ring_phase_monitor.sv
// Tracks a one-hot 16-bit ring counter that rotates toward bit 0, locks after LOCK_N good steps.
// Optional revolution counter is built only when RING_MON_REV_CNT_EN is defined.
module ring_phase_monitor #(
  parameter int LOCK_N = 2,
  parameter int REV_W  = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [15:0]      Ring_in,
  input  logic             Ring_vld,
  input  logic             Ld_seen,
  output logic [3:0]       Phase,
  output logic             One_hot,
  output logic             Locked,
  output logic             Err,
  output logic [7:0]       Err_cnt,
  output logic             Rev_tick,
  output logic [REV_W-1:0] Rev_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  function automatic logic is_one_hot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  function automatic logic [3:0] onehot_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic       one_hot_q, one_hot_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;

  logic       samp_oh;
  logic [3:0] samp_idx;
  logic       step_ok;
  logic [4:0] good_inc;

  assign samp_oh  = is_one_hot(Ring_in);
  assign samp_idx = onehot_index(Ring_in);
  // Expected motion is one position toward bit 0; 4-bit arithmetic makes 0 -> 15 the wrap.
  assign step_ok  = samp_oh && (samp_idx == (phase_q - 4'd1));
  assign good_inc = {1'b0, good_cnt_q} + 5'd1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    one_hot_d  = one_hot_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (Ring_vld) begin
      one_hot_d = samp_oh;
      if (samp_oh) phase_d = samp_idx;
    end

    // A parallel load upstream invalidates any tracking history.
    if (Ld_seen) begin
      good_cnt_d = 4'd0;
      state_d    = (Ring_vld && samp_oh) ? SYNC : HUNT;
    end else if (Ring_vld) begin
      unique case (state_q)
        HUNT: begin
          if (samp_oh) begin
            state_d    = SYNC;
            good_cnt_d = 4'd0;
          end
        end
        SYNC: begin
          if (step_ok) begin
            if (good_inc >= 5'(LOCK_N)) begin
              state_d    = LOCKED;
              good_cnt_d = 4'd0;
            end else begin
              good_cnt_d = good_inc[3:0];
            end
          end else begin
            err_d      = 1'b1;
            state_d    = HUNT;
            good_cnt_d = 4'd0;
          end
        end
        LOCKED: begin
          if (!step_ok) begin
            err_d   = 1'b1;
            state_d = FAULT;
          end
        end
        FAULT: begin
          if (samp_oh) begin
            state_d    = SYNC;
            good_cnt_d = 4'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (err_d) err_cnt_d = sat_inc8(err_cnt_q);
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q    <= HUNT;
      phase_q    <= 4'd0;
      one_hot_q  <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
      good_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      one_hot_q  <= one_hot_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  assign Phase   = phase_q;
  assign One_hot = one_hot_q;
  assign Locked  = locked_q;
  assign Err     = err_q;
  assign Err_cnt = err_cnt_q;

`ifdef RING_MON_REV_CNT_EN
  logic             rev_tick_q, rev_tick_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;

  // A revolution completes on a correct 0 -> 15 wrap observed while locked.
  always_comb begin
    rev_tick_d = 1'b0;
    rev_cnt_d  = rev_cnt_q;
    if (!Ld_seen && Ring_vld && (state_q == LOCKED) && step_ok && (phase_q == 4'd0)) begin
      rev_tick_d = 1'b1;
      rev_cnt_d  = rev_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      rev_tick_q <= 1'b0;
      rev_cnt_q  <= '0;
    end else begin
      rev_tick_q <= rev_tick_d;
      rev_cnt_q  <= rev_cnt_d;
    end
  end

  assign Rev_tick = rev_tick_q;
  assign Rev_cnt  = rev_cnt_q;
`else
  assign Rev_tick = 1'b0;
  assign Rev_cnt  = '0;
`endif

endmodule
